// File: rtl/mdu_seq.sv
// mdu_seq: iterative RV32M multiply/divide unit beside the EX ALU.
// One shift-add or restoring step per cycle, then sign fix-up.
module mdu_seq #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_op1,
  input  logic [XLEN-1:0] i_op2,
  input  logic            i_flush,
  output logic            o_ready,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_S = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ONES = {XLEN{1'b1}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t            state_q;
  logic [2:0]        f3_q;
  logic              neg_q;
  logic              s1_q;
  logic [CW-1:0]     cnt_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   b_q;
  logic [XLEN-1:0]   res_q;
  logic              done_q;

  logic            is_div;
  logic            op1_sgn;
  logic            op2_sgn;
  logic            sgn1;
  logic            sgn2;
  logic [XLEN-1:0] abs1;
  logic [XLEN-1:0] abs2;
  logic            div_zero;
  logic            div_ovf;
  logic            fast;
  logic [XLEN-1:0] fast_res;

  // Decode request: operand signedness, magnitudes and fast-path cases
  always_comb begin
    is_div  = i_funct3[2];
    op1_sgn = (i_funct3 == 3'b001) || (i_funct3 == 3'b010) ||
              (i_funct3 == 3'b100) || (i_funct3 == 3'b110);
    op2_sgn = (i_funct3 == 3'b001) || (i_funct3 == 3'b100) ||
              (i_funct3 == 3'b110);
    sgn1    = op1_sgn & i_op1[XLEN-1];
    sgn2    = op2_sgn & i_op2[XLEN-1];
    abs1    = sgn1 ? -i_op1 : i_op1;
    abs2    = sgn2 ? -i_op2 : i_op2;
    div_zero = is_div && (i_op2 == '0);
    div_ovf  = ((i_funct3 == 3'b100) || (i_funct3 == 3'b110)) &&
               (i_op1 == MIN_S) && (i_op2 == ONES);
    fast     = div_zero || div_ovf;
    fast_res = '0;
    unique case (1'b1)
      div_zero: fast_res = i_funct3[1] ? i_op1 : ONES;
      div_ovf:  fast_res = i_funct3[1] ? '0 : MIN_S;
      default:  fast_res = '0;
    endcase
  end

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_sh;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] div_next;

  // One iteration: shift-add for multiply, restoring step for divide
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} +
               (acc_q[0] ? {1'b0, b_q} : '0);
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
    div_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff = div_sh - {1'b0, b_q};
    div_next = {div_diff[XLEN] ? div_sh[XLEN-1:0]
                               : div_diff[XLEN-1:0],
                acc_q[XLEN-2:0], ~div_diff[XLEN]};
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   fix_res;

  // Sign fix-up and output word select
  always_comb begin
    prod = neg_q ? -acc_q : acc_q;
    quo  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem  = s1_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    fix_res = '0;
    unique case (1'b1)
      (f3_q == 3'b000): fix_res = prod[XLEN-1:0];
      (f3_q[2] == 1'b0 && f3_q != 3'b000):
        fix_res = prod[2*XLEN-1:XLEN];
      (f3_q[2:1] == 2'b10): fix_res = quo;
      (f3_q[2:1] == 2'b11): fix_res = rem;
      default: fix_res = '0;
    endcase
  end

  assign o_ready  = (state_q == IDLE);
  assign o_busy   = (state_q == CALC) || (state_q == FIX) ||
                    (i_valid && o_ready);
  assign o_done   = done_q;
  assign o_result = res_q;

  // Sequencer: accept, iterate, fix up, strobe result
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      f3_q    <= '0;
      neg_q   <= 1'b0;
      s1_q    <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
    end else if (i_flush) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (i_valid) begin
            f3_q  <= i_funct3;
            neg_q <= sgn1 ^ sgn2;
            s1_q  <= sgn1;
            cnt_q <= CW'(XLEN-1);
            acc_q <= {{XLEN{1'b0}}, is_div ? abs1 : abs2};
            b_q   <= is_div ? abs2 : abs1;
            if (fast) begin
              res_q   <= fast_res;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          acc_q <= f3_q[2] ? div_next : mul_next;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == '0) state_q <= FIX;
        end
        FIX: begin
          res_q   <= fix_res;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: directed checks of the iterative RV32M unit.
// Each task drives one scenario and compares inline.
module tb_mdu_seq;

  logic        clk;
  logic        rst_n;
  logic        i_valid;
  logic [2:0]  i_funct3;
  logic [31:0] i_op1;
  logic [31:0] i_op2;
  logic        i_flush;
  logic        o_ready;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_result;

  int errors = 0;
  int checks = 0;

  mdu_seq #(.XLEN(32)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_valid  (i_valid),
    .i_funct3 (i_funct3),
    .i_op1    (i_op1),
    .i_op2    (i_op2),
    .i_flush  (i_flush),
    .o_ready  (o_ready),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_result (o_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic run_op(input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] res,
                        output int edges);
    int w;
    @(negedge clk);
    w = 0;
    while (!o_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    i_funct3 = f;
    i_op1    = a;
    i_op2    = b;
    i_valid  = 1'b1;
    @(posedge clk);
    #1 i_valid = 1'b0;
    edges = 0;
    while (!o_done && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
    end
    if (!o_done) edges = -1;
    res = o_result;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (o_ready !== 1'b1 || o_busy !== 1'b0 ||
        o_done !== 1'b0 || o_result !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b busy=%b done=%b res=%h want 1 0 0 0",
               o_ready, o_busy, o_done, o_result);
    end
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (o_ready !== 1'b1 || o_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: rdy=%b done=%b want 1 0",
               o_ready, o_done);
    end
  endtask

  task automatic test_mul();
    logic [2:0]  f[4]  = '{3'b000, 3'b001, 3'b011, 3'b010};
    logic [31:0] a[4]  = '{32'd7, 32'h80000000, 32'hFFFFFFFF,
                           32'hFFFFFFFF};
    logic [31:0] b[4]  = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF,
                           32'hFFFFFFFF};
    logic [31:0] ex[4] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE,
                           32'hFFFFFFFF};
    logic [31:0] r;
    int e;
    for (int i = 0; i < 4; i++) begin
      run_op(f[i], a[i], b[i], r, e);
      checks++;
      if (r !== ex[i]) begin
        errors++;
        $display("FAIL mul_%0d result: got %h want %h", i, r, ex[i]);
      end
      checks++;
      if (e !== 33) begin
        errors++;
        $display("FAIL mul_%0d latency: got %0d edges want 33", i, e);
      end
    end
  endtask

  task automatic test_div();
    logic [2:0]  f[6]  = '{3'b100, 3'b110, 3'b101, 3'b111,
                           3'b100, 3'b110};
    logic [31:0] a[6]  = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100,
                           32'h80000000, 32'd7};
    logic [31:0] b[6]  = '{32'd2, 32'd2, 32'd7, 32'd7,
                           32'd2, 32'hFFFFFFFE};
    logic [31:0] ex[6] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2,
                           32'hC0000000, 32'd1};
    logic [31:0] r;
    int e;
    for (int i = 0; i < 6; i++) begin
      run_op(f[i], a[i], b[i], r, e);
      checks++;
      if (r !== ex[i] || e !== 33) begin
        errors++;
        $display("FAIL div_%0d: got %h/%0d want %h/33",
                 i, r, e, ex[i]);
      end
    end
  endtask

  task automatic test_fast_path();
    logic [2:0]  f[6]  = '{3'b100, 3'b111, 3'b101, 3'b110,
                           3'b100, 3'b110};
    logic [31:0] a[6]  = '{32'd5, 32'd5, 32'd9, 32'hDEADBEEF,
                           32'h80000000, 32'h80000000};
    logic [31:0] b[6]  = '{32'd0, 32'd0, 32'd0, 32'd0,
                           32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] ex[6] = '{32'hFFFFFFFF, 32'd5, 32'hFFFFFFFF,
                           32'hDEADBEEF, 32'h80000000, 32'd0};
    logic [31:0] r;
    int e;
    for (int i = 0; i < 6; i++) begin
      run_op(f[i], a[i], b[i], r, e);
      checks++;
      if (r !== ex[i] || e !== 0) begin
        errors++;
        $display("FAIL fast_%0d: got %h/%0d want %h/0",
                 i, r, e, ex[i]);
      end
    end
  endtask

  task automatic test_flush();
    logic [31:0] prev;
    logic [31:0] r;
    int e;
    int dones;
    prev = o_result;
    @(negedge clk);
    i_funct3 = 3'b000;
    i_op1    = 32'h1234;
    i_op2    = 32'h10;
    i_valid  = 1'b1;
    @(posedge clk);
    #1 i_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk) i_flush = 1'b1;
    @(posedge clk);
    #1 i_flush = 1'b0;
    checks++;
    if (o_ready !== 1'b1 || o_done !== 1'b0 || o_result !== prev) begin
      errors++;
      $display("FAIL flush_idle: rdy=%b done=%b res=%h want 1 0 %h",
               o_ready, o_done, o_result, prev);
    end
    dones = 0;
    repeat (40) begin
      @(posedge clk);
      #1 if (o_done) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL flush_no_done: got %0d strobes want 0", dones);
    end
    @(negedge clk);
    i_valid = 1'b1;
    i_flush = 1'b1;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_flush = 1'b0;
    checks++;
    if (o_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_blocks_accept: rdy=%b want 1", o_ready);
    end
    run_op(3'b000, 32'd3, 32'd4, r, e);
    checks++;
    if (r !== 32'd12 || e !== 33) begin
      errors++;
      $display("FAIL flush_then_mul: got %h/%0d want 0000000c/33", r, e);
    end
  endtask

  task automatic test_async_reset();
    int dones;
    @(negedge clk);
    i_funct3 = 3'b101;
    i_op1    = 32'd1000;
    i_op2    = 32'd3;
    i_valid  = 1'b1;
    @(posedge clk);
    #1 i_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    checks++;
    if (o_ready !== 1'b1 || o_busy !== 1'b0 ||
        o_done !== 1'b0 || o_result !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_calc: rdy=%b busy=%b done=%b res=%h want 1 0 0 0",
               o_ready, o_busy, o_done, o_result);
    end
    @(negedge clk) rst_n = 1'b1;
    dones = 0;
    repeat (40) begin
      @(posedge clk);
      #1 if (o_done) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL reset_no_done: got %0d strobes want 0", dones);
    end
  endtask

  task automatic test_handshake();
    int bad_busy;
    int bad_ready;
    int bad_done;
    @(negedge clk);
    i_funct3 = 3'b000;
    i_op1    = 32'd3;
    i_op2    = 32'd5;
    i_valid  = 1'b1;
    #1;
    checks++;
    if (o_busy !== 1'b1 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL hs_accept_cycle: busy=%b rdy=%b want 1 1",
               o_busy, o_ready);
    end
    bad_busy  = 0;
    bad_ready = 0;
    bad_done  = 0;
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      if (o_busy !== 1'b1) bad_busy++;
      if (o_ready !== 1'b0) bad_ready++;
      if (o_done !== 1'b0) bad_done++;
    end
    checks++;
    if (bad_busy !== 0 || bad_ready !== 0 || bad_done !== 0) begin
      errors++;
      $display("FAIL hs_window: busy_err=%0d rdy_err=%0d done_err=%0d want 0 0 0",
               bad_busy, bad_ready, bad_done);
    end
    @(negedge clk);
    checks++;
    if (o_done !== 1'b1 || o_busy !== 1'b0 || o_ready !== 1'b0 ||
        o_result !== 32'd15) begin
      errors++;
      $display("FAIL hs_done_cycle: done=%b busy=%b rdy=%b res=%h want 1 0 0 0000000f",
               o_done, o_busy, o_ready, o_result);
    end
    i_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (o_done !== 1'b0 || o_ready !== 1'b1 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL hs_after_done: done=%b rdy=%b busy=%b want 0 1 0",
               o_done, o_ready, o_busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r0;
    logic [31:0] r1;
    logic [31:0] r2;
    int e0;
    int e1;
    int e2;
    run_op(3'b101, 32'd100, 32'd7, r0, e0);
    run_op(3'b111, 32'd100, 32'd7, r1, e1);
    run_op(3'b000, 32'd7, 32'hFFFFFFFD, r2, e2);
    checks++;
    if (r0 !== 32'd14 || r1 !== 32'd2 || r2 !== 32'hFFFFFFEB) begin
      errors++;
      $display("FAIL b2b_results: got %h %h %h want 0000000e 00000002 ffffffeb",
               r0, r1, r2);
    end
    checks++;
    if (e0 !== 33 || e1 !== 33 || e2 !== 33) begin
      errors++;
      $display("FAIL b2b_latency: got %0d %0d %0d want 33 33 33",
               e0, e1, e2);
    end
  endtask

  initial begin
    i_valid  = 1'b0;
    i_funct3 = 3'b000;
    i_op1    = '0;
    i_op2    = '0;
    i_flush  = 1'b0;
    rst_n    = 1'b0;
    test_reset();
    test_mul();
    test_div();
    test_fast_path();
    test_flush();
    test_async_reset();
    test_handshake();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
